// File: rtl/tbec_pkg.sv
// Shared types and sizing helpers for the SEC-DED protected memory.
package tbec_pkg;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_CORR = 2'b01,
      ERR_DBL  = 2'b10
   } err_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CHK,
      ST_WB
`ifdef TBEC_SCRUB_EN
      , ST_SCRUB_RD
      , ST_SCRUB_CHK
`endif
   } state_t;

   // Check bits including overall parity: r+1, smallest r with 2**r >= data_w+r+1.
   function automatic int calc_p(input int data_w);
      int r;
      r = 1;
      while ((1 << r) < data_w + r + 1) r = r + 1;
      return r + 1;
   endfunction

endpackage

// File: rtl/tbec_ecc_mem_if.sv
// Request/response bus between the host master and the protected memory.
interface tbec_ecc_mem_if import tbec_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   localparam int CW = DATA_W + calc_p(DATA_W);

   logic              req_valid;
   logic              req_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] tbec_addr;
   logic [DATA_W-1:0] data_in;
   logic [CW-1:0]     inj_mask;
   logic              rsp_valid;
   logic [DATA_W-1:0] data_out;
   err_code_t         out_error_code;

   modport master (
      output req_valid, mem_we, tbec_addr, data_in, inj_mask,
      input  req_ready, rsp_valid, data_out, out_error_code
   );

   modport slave (
      input  req_valid, mem_we, tbec_addr, data_in, inj_mask,
      output req_ready, rsp_valid, data_out, out_error_code
   );
endinterface

// File: rtl/tbec_secded_codec.sv
// Combinational extended-Hamming codec: check bits at power-of-two positions,
// overall parity in the codeword MSB.
module tbec_secded_codec import tbec_pkg::*; #(
   parameter  int DATA_W = 16,
   localparam int CW     = DATA_W + calc_p(DATA_W)
) (
   input  logic [DATA_W-1:0] enc_data,
   output logic [CW-1:0]     enc_cw,
   input  logic [CW-1:0]     dec_cw,
   output logic [DATA_W-1:0] dec_data,
   output err_code_t         dec_code,
   output logic [CW-1:0]     dec_fix
);
   localparam int R    = calc_p(DATA_W) - 1;
   localparam int N    = DATA_W + R;
   localparam int DI_W = $clog2(DATA_W);

   always_comb begin : encode
      logic [N:1]      h;
      logic [DI_W-1:0] d;
      logic            par;
      h = '0;
      d = '0;
      for (int pos = 1; pos <= N; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            h[pos] = enc_data[d];
            d = d + DI_W'(1);
         end
      end
      for (int k = 0; k < R; k++) begin
         par = 1'b0;
         for (int pos = 1; pos <= N; pos++) begin
            if (((pos >> k) & 1) == 1) par = par ^ h[pos];
         end
         h[1 << k] = par;
      end
      enc_cw = {^h, h};
   end

   always_comb begin : decode
      logic [N:1]      h;
      logic [R-1:0]    syn;
      logic            found;
      logic [DI_W-1:0] d;
      h   = dec_cw[N-1:0];
      syn = '0;
      for (int k = 0; k < R; k++) begin
         for (int pos = 1; pos <= N; pos++) begin
            if (((pos >> k) & 1) == 1) syn[k] = syn[k] ^ h[pos];
         end
      end
      dec_fix  = dec_cw;
      dec_code = ERR_NONE;
      found    = 1'b0;
      // Odd parity means one flip; a syndrome beyond N can only come from 3+ flips.
      if (^dec_cw) begin
         if (syn == '0) begin
            dec_fix[CW-1] = ~dec_fix[CW-1];
            found = 1'b1;
         end else begin
            for (int pos = 1; pos <= N; pos++) begin
               if (syn == R'(pos)) begin
                  dec_fix[pos-1] = ~dec_fix[pos-1];
                  found = 1'b1;
               end
            end
         end
         dec_code = found ? ERR_CORR : ERR_DBL;
      end else if (syn != '0) begin
         dec_code = ERR_DBL;
      end
      dec_data = '0;
      d = '0;
      for (int pos = 1; pos <= N; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            dec_data[d] = dec_fix[pos-1];
            d = d + DI_W'(1);
         end
      end
   end
endmodule

// File: rtl/tbec_ecc_mem.sv
// SEC-DED protected single-port memory with write-back of corrected words.
// Background scrubber is built when TBEC_SCRUB_EN is defined.
//
// state        | meaning
// ST_IDLE      | ready for a host request (or a pending scrub)
// ST_RD        | array read of the host address
// ST_CHK       | decode, register response and error bookkeeping
// ST_WB        | write corrected codeword back (single-bit errors only)
// ST_SCRUB_RD  | array read of scrub_addr
// ST_SCRUB_CHK | decode scrub word, no response
module tbec_ecc_mem import tbec_pkg::*; #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 8,
   parameter int CNT_W        = 16,
   parameter int SCRUB_PERIOD = 1024
) (
   input  logic              tbec_clk,
   input  logic              tbec_rst,
   tbec_ecc_mem_if.slave     bus,
   output logic [ADDR_W-1:0] err_addr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);
   localparam int CW    = DATA_W + calc_p(DATA_W);
   localparam int DEPTH = 2 ** ADDR_W;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [CW-1:0]     rd_cw;
   logic [CW-1:0]     fix_q;
   logic [CW-1:0]     mem [DEPTH];

   logic [CW-1:0]     enc_cw;
   logic [CW-1:0]     dec_fix;
   logic [DATA_W-1:0] dec_data;
   err_code_t         dec_code;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [CW-1:0]     wr_cw;
   logic              rd_accept;
   logic              chk_phase;

   tbec_secded_codec #(.DATA_W(DATA_W)) u_codec (
      .enc_data (bus.data_in),
      .enc_cw   (enc_cw),
      .dec_cw   (rd_cw),
      .dec_data (dec_data),
      .dec_code (dec_code),
      .dec_fix  (dec_fix)
   );

   assign rd_accept = bus.req_valid && bus.req_ready && !bus.mem_we;

`ifdef TBEC_SCRUB_EN
   localparam int TMR_W = $clog2(SCRUB_PERIOD + 1);
   logic [TMR_W-1:0]  scrub_tmr;
   logic              scrub_pend;
   logic [ADDR_W-1:0] scrub_addr;
   assign chk_phase = (state == ST_CHK) || (state == ST_SCRUB_CHK);
`else
   logic unused_scrub_period;
   assign unused_scrub_period = ^SCRUB_PERIOD;
   assign chk_phase = (state == ST_CHK);
`endif

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = bus.tbec_addr;
      wr_cw   = enc_cw ^ bus.inj_mask;
      if (state == ST_IDLE && bus.req_valid && bus.req_ready && bus.mem_we) begin
         wr_en = 1'b1;
      end else if (state == ST_WB) begin
         wr_en   = 1'b1;
         wr_addr = addr_q;
         wr_cw   = fix_q;
      end
      if (tbec_rst) wr_en = 1'b0;
   end

   always_ff @(posedge tbec_clk) begin
      if (wr_en) mem[wr_addr] <= wr_cw;
   end

   always_ff @(posedge tbec_clk) begin
      if (tbec_rst) begin
         state              <= ST_IDLE;
         bus.req_ready      <= 1'b0;
         bus.rsp_valid      <= 1'b0;
         bus.data_out       <= '0;
         bus.out_error_code <= ERR_NONE;
         err_addr           <= '0;
         corr_cnt           <= '0;
         uncorr_cnt         <= '0;
         addr_q             <= '0;
         rd_cw              <= '0;
         fix_q              <= '0;
`ifdef TBEC_SCRUB_EN
         scrub_tmr          <= TMR_W'(SCRUB_PERIOD - 1);
         scrub_pend         <= 1'b0;
         scrub_addr         <= '0;
`endif
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_accept) begin
                  state         <= ST_RD;
                  bus.req_ready <= 1'b0;
                  addr_q        <= bus.tbec_addr;
               end
`ifdef TBEC_SCRUB_EN
               else if (scrub_pend && !bus.req_valid) begin
                  state         <= ST_SCRUB_RD;
                  bus.req_ready <= 1'b0;
                  addr_q        <= scrub_addr;
                  scrub_pend    <= 1'b0;
               end
`endif
               else begin
                  bus.req_ready <= 1'b1;
               end
            end
            ST_RD: begin
               rd_cw <= mem[addr_q];
               state <= ST_CHK;
            end
            ST_CHK: begin
               bus.rsp_valid      <= 1'b1;
               bus.data_out       <= dec_data;
               bus.out_error_code <= dec_code;
               fix_q              <= dec_fix;
               if (dec_code == ERR_CORR) begin
                  state <= ST_WB;
               end else begin
                  state         <= ST_IDLE;
                  bus.req_ready <= 1'b1;
               end
            end
            ST_WB: begin
               state         <= ST_IDLE;
               bus.req_ready <= 1'b1;
            end
`ifdef TBEC_SCRUB_EN
            ST_SCRUB_RD: begin
               rd_cw <= mem[addr_q];
               state <= ST_SCRUB_CHK;
            end
            ST_SCRUB_CHK: begin
               fix_q      <= dec_fix;
               scrub_addr <= scrub_addr + ADDR_W'(1);
               if (dec_code == ERR_CORR) begin
                  state <= ST_WB;
               end else begin
                  state         <= ST_IDLE;
                  bus.req_ready <= 1'b1;
               end
            end
`endif
            default: begin
               state         <= ST_IDLE;
               bus.req_ready <= 1'b1;
            end
         endcase

         if (chk_phase && dec_code != ERR_NONE) begin
            err_addr <= addr_q;
            if (dec_code == ERR_CORR) begin
               if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
            end else begin
               if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
         end

`ifdef TBEC_SCRUB_EN
         // Idle-time down-counter; parks at terminal count until the scrub runs.
         if (state == ST_IDLE && !scrub_pend) begin
            if (scrub_tmr == '0) begin
               scrub_pend <= 1'b1;
               scrub_tmr  <= TMR_W'(SCRUB_PERIOD - 1);
            end else begin
               scrub_tmr <= scrub_tmr - TMR_W'(1);
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_tbec_ecc_mem.sv
// Scoreboard bench for tbec_ecc_mem: random reads/writes with fault injection
// against a word-level model of stored data and injected flip masks.
module tb_tbec_ecc_mem;
   import tbec_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int CNTW  = 16;
   localparam int CW    = 22;
   localparam int NADDR = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tbec_ecc_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
   logic [AW-1:0]   err_addr;
   logic [CNTW-1:0] corr_cnt;
   logic [CNTW-1:0] uncorr_cnt;

   tbec_ecc_mem #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CNTW), .SCRUB_PERIOD(1024)) dut (
      .tbec_clk   (clk),
      .tbec_rst   (rst),
      .bus        (bus),
      .err_addr   (err_addr),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
   );

   typedef struct {
      logic [DW-1:0]   data;
      logic [1:0]      code;
      logic [AW-1:0]   eaddr;
      logic [CNTW-1:0] ccnt;
      logic [CNTW-1:0] ucnt;
      int              cyc;
   } exp_t;

   exp_t sb[$];

   logic [DW-1:0] m_data [NADDR];
   logic [CW-1:0] m_mask [NADDR];
   int            m_corr;
   int            m_unc;
   logic [AW-1:0] m_eaddr;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Data bits fill the non-power-of-two positions 1..21 in order; bit i is position i+1.
   function automatic logic [DW-1:0] raw_flip(input logic [CW-1:0] mask);
      logic [DW-1:0] f;
      int di;
      f  = '0;
      di = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (mask[pos-1]) f[di] = 1'b1;
            di++;
         end
      end
      return f;
   endfunction

   function automatic logic [CW-1:0] rand_mask();
      int k, b1, b2;
      k = $urandom_range(0, 4);
      if (k <= 2) return '0;
      b1 = $urandom_range(0, CW - 1);
      if (k == 3) return CW'(1) << b1;
      b2 = b1;
      while (b2 == b1) b2 = $urandom_range(0, CW - 1);
      return (CW'(1) << b1) | (CW'(1) << b2);
   endfunction

   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [CW-1:0] m, input bit want_rsp);
      int   waited;
      int   idx;
      exp_t e;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.mem_we    = we;
      bus.tbec_addr = a;
      bus.data_in   = d;
      bus.inj_mask  = m;
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 16) begin
         @(negedge clk);
         waited++;
      end
      if (bus.req_ready !== 1'b1) begin
         chk("ready_timeout", waited, 0);
         return;
      end
      @(posedge clk);
      #1;
      idx = int'(a) % NADDR;
      if (we) begin
         m_data[idx] = d;
         m_mask[idx] = m;
      end else begin
         chk("ready_drop", bus.req_ready, 0);
         if (want_rsp) begin
            e.data = m_data[idx];
            e.code = 2'b00;
            if ($countones(m_mask[idx]) == 1) begin
               e.code = 2'b01;
               if (m_corr < 65535) m_corr++;
               m_eaddr = a;
               m_mask[idx] = '0;
            end else if ($countones(m_mask[idx]) == 2) begin
               e.code = 2'b10;
               e.data = m_data[idx] ^ raw_flip(m_mask[idx]);
               if (m_unc < 65535) m_unc++;
               m_eaddr = a;
            end
            e.eaddr = m_eaddr;
            e.ccnt  = CNTW'(m_corr);
            e.ucnt  = CNTW'(m_unc);
            e.cyc   = cyc + 2;
            sb.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", bus.rsp_valid, 0);
         end else begin
            e = sb.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("data_out", bus.data_out, e.data);
            chk("error_code", bus.out_error_code, e.code);
            chk("err_addr", err_addr, e.eaddr);
            chk("corr_cnt", corr_cnt, e.ccnt);
            chk("uncorr_cnt", uncorr_cnt, e.ucnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] a;
      bus.req_valid = 1'b0;
      bus.mem_we    = 1'b0;
      bus.tbec_addr = '0;
      bus.data_in   = '0;
      bus.inj_mask  = '0;
      m_corr  = 0;
      m_unc   = 0;
      m_eaddr = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_error_code", bus.out_error_code, 0);
      chk("rst_corr_cnt", corr_cnt, 0);
      chk("rst_uncorr_cnt", uncorr_cnt, 0);
      chk("rst_err_addr", err_addr, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_before_first_edge", bus.req_ready, 0);
      @(negedge clk);
      chk("ready_after_release", bus.req_ready, 1);

      for (int i = 0; i < NADDR; i++) issue(1'b1, AW'(i), DW'($urandom), '0, 1'b1);

      issue(1'b1, 8'h01, 16'hE1F0, '0, 1'b1);
      issue(1'b0, 8'h01, '0, '0, 1'b1);
      issue(1'b1, 8'h01, 16'hE1F0, CW'(1) << 3, 1'b1);
      issue(1'b0, 8'h01, '0, '0, 1'b1);
      issue(1'b0, 8'h01, '0, '0, 1'b1);
      issue(1'b1, 8'h01, 16'hE1F0, (CW'(1) << 3) | (CW'(1) << 9), 1'b1);
      issue(1'b0, 8'h01, '0, '0, 1'b1);
      issue(1'b0, 8'h01, '0, '0, 1'b1);
      idle(2);
      drain();
      chk("dir_uncorr_cnt", uncorr_cnt, 2);
      chk("dir_corr_cnt", corr_cnt, 1);

      for (int i = 0; i < 300; i++) begin
         a = AW'($urandom_range(0, NADDR - 1));
         if ($urandom_range(0, 2) == 0) issue(1'b1, a, DW'($urandom), rand_mask(), 1'b1);
         else issue(1'b0, a, '0, '0, 1'b1);
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
      end
      idle(2);
      drain();

      issue(1'b1, 8'h05, 16'h5A5A, '0, 1'b1);
      issue(1'b0, 8'h05, '0, '0, 1'b0);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready", bus.req_ready, 0);
      rst = 1'b0;
      m_corr  = 0;
      m_unc   = 0;
      m_eaddr = '0;
      @(negedge clk);
      chk("midrst_ready_hold", bus.req_ready, 0);
      chk("midrst_corr_cnt", corr_cnt, 0);
      chk("midrst_uncorr_cnt", uncorr_cnt, 0);
      chk("midrst_err_addr", err_addr, 0);
      @(negedge clk);
      chk("midrst_ready_back", bus.req_ready, 1);
      idle(4);
      issue(1'b0, 8'h05, '0, '0, 1'b1);
      idle(2);
      drain();

      chk("final_corr_cnt", corr_cnt, CNTW'(m_corr));
      chk("final_uncorr_cnt", uncorr_cnt, CNTW'(m_unc));
      chk("final_err_addr", err_addr, m_eaddr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tbec_ecc_mem.md
# tbec_ecc_mem

Parametrised SEC-DED protected single-port memory with a request/response handshake, error reporting and saturating error counters. It is the next-generation replacement for the fixed 16-bit × 256 protected memory. It adds configurable width and depth, automatic write-back of corrected words, fault injection and an optional background scrubber. It sits between a host-side request master and the on-chip storage array.

## Interface
- DATA_W, 16, data word width (≥4)
- ADDR_W, 8, address width; depth = 2**ADDR_W
- CNT_W, 16, error counter width
- SCRUB_PERIOD, 1024, idle cycles between scrub slots (used only with scrubber compiled in)
- tbec_clk  in  1  clock, all logic on rising edge
- tbec_rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- mem_we  in  1  1 = write, 0 = read (sampled with request)
- tbec_addr  in  ADDR_W  request address
- data_in  in  DATA_W  write data
- inj_mask  in  CW  XOR mask applied to the encoded codeword on write (CW = DATA_W + P)
- rsp_valid  out  1  one-cycle read response strobe
- data_out  out  DATA_W  read data (corrected when possible)
- out_error_code  out  2  00 clean, 01 single corrected, 10 double detected, 11 never driven
- err_addr  out  ADDR_W  address of most recent non-clean read
- corr_cnt  out  CNT_W  saturating count of code-01 events
- uncorr_cnt  out  CNT_W  saturating count of code-10 events

## Operation
- P = r+1, where r is the smallest value with 2**r ≥ DATA_W+r+1. DATA_W=16 gives P=6, CW=22.
- Encoding is extended Hamming. Check bits sit at power-of-two positions and the overall parity bit is the MSB.
- A request is accepted on an edge where req_valid && req_ready.
- Write: encode data_in, XOR with inj_mask, store at tbec_addr. No response is produced.
- Read: read the codeword, decode, then drive data_out, out_error_code and a one-cycle rsp_valid.
- Code 01 (error in data or check bit): data_out is corrected. The corrected codeword is written back to the same address, with no injection applied.
- Code 10: data_out carries the raw data bits. There is no write-back.
- On any non-clean read, err_addr is updated and the relevant counter increments. Counters saturate at all-ones.
- FSM states:
  - IDLE: req_ready=1.
  - RD: array read.
  - CHK: decode, register outputs.
  - WB: write-back, entered only on code 01.
  - SCRUB_RD / SCRUB_CHK: scrubber only.
  - Transitions: IDLE→RD on an accepted read. RD→CHK. CHK→WB if code 01, else IDLE. WB→IDLE.
- req_ready is 1 only in IDLE. Requests presented outside IDLE are not accepted and must be held by the master.
- Reset clears FSM, outputs, counters, err_addr and the scrub state. Array contents are not cleared.

## Timing
- Write accepted at edge T: data is visible to a read accepted at T+1.
- Read accepted at edge T: rsp_valid, data_out and out_error_code are registered at T+2. rsp_valid is high for exactly one cycle.
- data_out and out_error_code hold their values until the next response.
- Minimum read-to-read spacing is 3 cycles, or 4 with write-back.
- Reset values: req_ready=0 during reset and 1 the cycle after; all other outputs 0.
- Reset asserted mid-read: the response is suppressed. rsp_valid stays 0 and there is no write-back.

## Configuration
- TBEC_SCRUB_EN defined:
  - A cycle counter counts SCRUB_PERIOD cycles spent in IDLE, then raises scrub_pend.
  - In IDLE with scrub_pend set and no req_valid, the FSM enters SCRUB_RD at scrub_addr.
  - Decode, counters and err_addr behave as for a host read. Write-back goes through WB. No rsp_valid is generated.
  - scrub_addr increments after each scrub and wraps from 2**ADDR_W−1 to 0.
  - A host request in the same cycle wins; the scrub remains pending.
- TBEC_SCRUB_EN undefined: no scrub logic is built and the SCRUB_* states do not exist.

## Structure
- tbec_pkg: error-code enum, FSM state enum, and a function computing P from DATA_W.
- Sub-module tbec_secded_codec, parametrised on DATA_W, purely combinational. Encode: data→codeword. Decode: codeword→data, error code.
- The top level holds the array, FSM, counters and scrubber.

## Test plan
- Reset, write 16'hE1F0 at 8'h01, read 8'h01 → rsp_valid at T+2, data_out 16'hE1F0, code 00, counters 0.
- Write 16'hE1F0 with inj_mask bit 3 set, read → data_out 16'hE1F0, code 01, corr_cnt 1, err_addr 8'h01. A second read returns code 00 (write-back verified).
- inj_mask with bits 3 and 9 set, read twice → code 10 both times, uncorr_cnt 2, no write-back.
- Hold req_valid continuously with alternating reads → req_ready low during RD/CHK/WB, no request lost or duplicated, responses in order.
- Assert tbec_rst in the cycle after read acceptance → no rsp_valid, counters 0, req_ready 1 after release.
- With TBEC_SCRUB_EN and SCRUB_PERIOD=16: inject a single error at 8'h00, idle 40 cycles → corr_cnt 1, no rsp_valid. A host read of 8'h00 then returns code 00.
